// File: rtl/apb_regbank_pkg.sv
// Shared FSM state codes and decode error-cause encoding for the APB register bank.
package apb_regbank_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   // Cause codes are prioritised range > align > read-only when several apply.
   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_RANGE = 2'd1;
   localparam logic [1:0] ERR_ALIGN = 2'd2;
   localparam logic [1:0] ERR_RO    = 2'd3;

endpackage

// File: rtl/apb_regbank_decode.sv
// Combinational APB address decode: word index plus error-cause classification.
module apb_regbank_decode
   import apb_regbank_pkg::*;
#(
   parameter int                  ADDR_WIDTH = 6,
   parameter int                  NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  pwrite,
   output logic [ADDR_WIDTH-3:0] idx,
   output logic [1:0]            err_cause
);

   localparam int IW = ADDR_WIDTH - 2;

   logic out_range;
   logic ro_hit;

   assign idx       = paddr[ADDR_WIDTH-1:2];
   assign out_range = ({1'b0, idx} >= (IW+1)'(NUM_REGS));

   // Only implemented indices can be read-only; out-of-range is reported first anyway.
   always_comb begin
      ro_hit = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == IW'(i)) ro_hit = RO_MASK[i];
      end
   end

   always_comb begin
      err_cause = ERR_NONE;
      if (out_range)              err_cause = ERR_RANGE;
      else if (paddr[1:0] != 2'b00) err_cause = ERR_ALIGN;
      else if (pwrite && ro_hit)  err_cause = ERR_RO;
   end

endmodule

// File: rtl/apb_regbank_ws.sv
// APB slave register bank with configurable wait states, byte strobes and read-only masking.
module apb_regbank_ws
   import apb_regbank_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 6,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_REGS    = 16,
   parameter int                    WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                           PCLK,
   input  logic                           PRESETn,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic                           PWRITE,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
   input  logic [DATA_WIDTH/8-1:0]        PSTRB,
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic                           PREADY,
   output logic                           PSLVERR,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int         IW = ADDR_WIDTH - 2;
   localparam int         NB = DATA_WIDTH / 8;
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   logic [0:0]            state;
   logic [3:0]            wcnt;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   wr_pulse_q;

   logic [IW-1:0]         idx;
   logic [1:0]            err_cause;
   logic                  dec_err;
   logic                  done;
   logic                  viol;
   logic                  commit;
   logic [DATA_WIDTH-1:0] rd_word;

   apb_regbank_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .RO_MASK    (RO_MASK)
   ) u_decode (
      .paddr     (PADDR),
      .pwrite    (PWRITE),
      .idx       (idx),
      .err_cause (err_cause)
   );

   assign dec_err = (err_cause != ERR_NONE);
   // Gating with PRESETn keeps the response silent while reset is held.
   assign done    = PRESETn && (state == ST_ACCESS) && PSEL && PENABLE && (wcnt == 4'd0);
   assign viol    = PRESETn && (state == ST_IDLE) && PSEL && PENABLE;
   assign commit  = done && PWRITE && !dec_err;

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == IW'(i)) rd_word = regs[i];
      end
   end

   assign PREADY  = done | viol;
   assign PSLVERR = viol | (done & dec_err);
   assign PRDATA  = (done && !PWRITE && !dec_err) ? rd_word : '0;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= ST_IDLE;
         wcnt  <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (PSEL && !PENABLE) begin
                  state <= ST_ACCESS;
                  wcnt  <= WS;
               end
            end
            default: begin
               if (!PSEL) begin
                  state <= ST_IDLE;
               end else if (!PENABLE) begin
                  wcnt <= WS;
               end else if (wcnt != 4'd0) begin
                  wcnt <= wcnt - 4'd1;
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
         wr_pulse_q <= '0;
      end else begin
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && (idx == IW'(i))) begin
               wr_pulse_q[i] <= 1'b1;
               for (int b = 0; b < NB; b++) begin
                  if (PSTRB[b]) regs[i][b*8 +: 8] <= PWDATA[b*8 +: 8];
               end
            end
         end
      end
   end

   assign reg_wr_pulse = wr_pulse_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end

endmodule

// File: tb/tb_apb_regbank_ws.sv
// Scoreboard bench for apb_regbank_ws: directed plan items followed by randomized traffic.
module tb_apb_regbank_ws;

   localparam int          AW  = 7;
   localparam int          NR  = 16;
   localparam int          WS  = 3;
   localparam logic [15:0] RO  = 16'h0008;
   localparam logic [31:0] RSTV = 32'hA5A5_0000;

   logic           PCLK = 1'b0;
   logic           PRESETn = 1'b0;
   logic           PSEL = 1'b0;
   logic           PENABLE = 1'b0;
   logic [AW-1:0]  PADDR = '0;
   logic           PWRITE = 1'b0;
   logic [31:0]    PWDATA = '0;
   logic [3:0]     PSTRB = '0;
   logic [31:0]    PRDATA;
   logic           PREADY;
   logic           PSLVERR;
   logic [NR*32-1:0] reg_out;
   logic [NR-1:0]  reg_wr_pulse;

   apb_regbank_ws #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (32), .NUM_REGS (NR),
      .WAIT_STATES (WS), .RO_MASK (RO), .RESET_VALUE (RSTV)
   ) dut (
      .PCLK (PCLK), .PRESETn (PRESETn), .PSEL (PSEL), .PENABLE (PENABLE),
      .PADDR (PADDR), .PWRITE (PWRITE), .PWDATA (PWDATA), .PSTRB (PSTRB),
      .PRDATA (PRDATA), .PREADY (PREADY), .PSLVERR (PSLVERR),
      .reg_out (reg_out), .reg_wr_pulse (reg_wr_pulse)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic        err;
      logic        rd;
      logic [31:0] rdata;
      logic [15:0] pulse;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mdl [NR];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) mdl[i] = RSTV;
   endtask

   task automatic check_regs(input string name);
      for (int i = 0; i < NR; i++) chk(name, 64'(reg_out[i*32 +: 32]), 64'(mdl[i]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge PCLK);
      #1;
   endtask

   // Called just after a rising edge; leaves the bus idle just after the completion edge.
   task automatic xfer(input logic wr, input logic [AW-1:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
      exp_t e;
      int   idx;
      int   cyc;
      logic ro;
      idx = int'(addr) >> 2;
      ro  = (idx < NR) ? RO[idx] : 1'b0;
      e.err   = (idx >= NR) || (addr[1:0] != 2'b00) || (wr && ro);
      e.rd    = !wr;
      e.rdata = (!wr && !e.err) ? mdl[idx] : 32'h0;
      e.pulse = (wr && !e.err) ? 16'(1 << idx) : 16'h0;
      exp_q.push_back(e);
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = data; PSTRB = strb;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      cyc = 0;
      do begin
         @(negedge PCLK);
         cyc++;
      end while (!PREADY && cyc < 40);
      chk("access_cycles", 64'(cyc), 64'(WS + 1));
      if (wr && !e.err) begin
         chk("reg_before_commit", 64'(reg_out[idx*32 +: 32]), 64'(mdl[idx]));
         for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   // Monitor: every response the DUT presents is matched against the scoreboard queue.
   initial begin
      exp_t        e;
      logic [15:0] pend;
      pend = '0;
      forever begin
         @(negedge PCLK);
         if (!PRESETn) begin
            pend = '0;
         end else begin
            chk("wr_pulse", 64'(reg_wr_pulse), 64'(pend));
            pend = '0;
            if (PREADY) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_pready", 64'(PREADY), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  chk("pslverr", 64'(PSLVERR), 64'(e.err));
                  if (e.rd) chk("prdata", 64'(PRDATA), 64'(e.rdata));
                  pend = e.pulse;
               end
            end else begin
               chk("idle_outputs", {31'h0, PSLVERR, PRDATA}, 64'h0);
            end
         end
      end
   end

   initial begin
      model_reset();
      // Reset held with a bogus access on the bus: response must stay silent.
      #12;
      PSEL = 1'b1; PENABLE = 1'b1;
      #10;
      chk("reset_outputs", {30'h0, PREADY, PSLVERR, PRDATA}, 64'h0);
      chk("reset_pulse", 64'(reg_wr_pulse), 64'h0);
      check_regs("reset_reg");
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK); PRESETn = 1'b1;
      @(posedge PCLK); #1;

      xfer(1'b0, 7'h08, 32'h0, 4'h0);                 // reset default
      xfer(1'b1, 7'h04, 32'hFFFF_FFFF, 4'hF);
      xfer(1'b1, 7'h04, 32'h1122_3344, 4'b0101);      // byte strobes
      xfer(1'b0, 7'h04, 32'h0, 4'h0);
      xfer(1'b1, 7'h00, 32'hDEAD_BEEF, 4'hF);
      xfer(1'b1, 7'h14, 32'h1234_5678, 4'h0);         // empty strobe still pulses
      xfer(1'b1, 7'h40, 32'h5555_5555, 4'hF);         // out of range
      xfer(1'b0, 7'h02, 32'h0, 4'h0);                 // misaligned
      xfer(1'b1, 7'h0C, 32'h7777_7777, 4'hF);         // read-only
      xfer(1'b0, 7'h0C, 32'h0, 4'h0);
      check_regs("directed_reg");

      // Access phase without a setup phase.
      exp_q.push_back('{err: 1'b1, rd: 1'b0, rdata: 32'h0, pulse: 16'h0});
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 7'h08; PWDATA = 32'h0BAD_0BAD; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      idle(1);

      // PSEL dropped during a wait state aborts without writing.
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 7'h18; PWDATA = 32'hCAFE_F00D; PSTRB = 4'hF;
      @(posedge PCLK); #1; PENABLE = 1'b1;
      idle(2);
      PSEL = 1'b0; PENABLE = 1'b0;
      idle(1);
      check_regs("protocol_reg");
      xfer(1'b0, 7'h18, 32'h0, 4'h0);

      // Reset in the middle of a write's wait states.
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 7'h00; PWDATA = 32'h0123_4567; PSTRB = 4'hF;
      @(posedge PCLK); #1; PENABLE = 1'b1;
      @(negedge PCLK); #2;
      PRESETn = 1'b0;
      #1;
      model_reset();
      chk("midreset_outputs", {30'h0, PREADY, PSLVERR, PRDATA}, 64'h0);
      check_regs("midreset_reg");
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK); PRESETn = 1'b1;
      @(posedge PCLK); #1;
      xfer(1'b0, 7'h00, 32'h0, 4'h0);
      xfer(1'b1, 7'h00, 32'h0F0F_0F0F, 4'b1001);
      xfer(1'b0, 7'h00, 32'h0, 4'h0);

      // Randomized traffic, mostly aligned in-range, with occasional gaps.
      for (int n = 0; n < 150; n++) begin
         logic [AW-1:0] a;
         if ($urandom_range(0, 3) == 0) a = AW'($urandom);
         else a = {AW'($urandom_range(0, NR - 1)) << 2};
         xfer(1'($urandom), a, $urandom, 4'($urandom));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(3);
      check_regs("final_reg");
      chk("queue_drained", 64'(exp_q.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
